// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock synchronous FIFO with in-block occupancy tracking, programmable
//   almost-full/almost-empty thresholds and a registered read port (1-cycle
//   read latency).
//
// Optional build macro:
//   SYNC_FIFO_ERR_FLAGS_EN - adds sticky overflow/underflow error flags and
//                            their clear input.
//
// Ports:
//   i_clk            clock, all logic on rising edge
//   i_rst            synchronous active-high reset
//   i_wrdata         write data
//   i_wr_en          write request (accepted when not full)
//   i_rd_en          read request (accepted when not empty)
//   o_rdata          registered read data, holds when no read is accepted
//   o_rdata_valid    one-cycle pulse when o_rdata carries a newly popped word
//   o_full           count == DEPTH
//   o_empty          count == 0
//   o_almost_full    count >= ALMOST_FULL_TH
//   o_almost_empty   count <= ALMOST_EMPTY_TH
//   o_count          current occupancy, 0..DEPTH
//   o_overflow       (macro) sticky write-when-full
//   o_underflow      (macro) sticky read-when-empty
//   i_err_clr        (macro) clears both sticky flags; a coincident set wins
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_W          = 8,
  parameter int ADDRESS         = 4,
  parameter int ALMOST_FULL_TH  = 12,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [DATA_W-1:0]  i_wrdata,
  input  logic               i_wr_en,
  input  logic               i_rd_en,
  output logic [DATA_W-1:0]  o_rdata,
  output logic               o_rdata_valid,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_almost_full,
  output logic               o_almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  output logic               o_overflow,
  output logic               o_underflow,
  input  logic               i_err_clr,
`endif
  output logic [ADDRESS:0]   o_count
);

  localparam int DEPTH = 1 << ADDRESS;

  localparam logic [ADDRESS:0] C_DEPTH = (ADDRESS+1)'(DEPTH);
  localparam logic [ADDRESS:0] C_AF_TH = (ADDRESS+1)'(ALMOST_FULL_TH);
  localparam logic [ADDRESS:0] C_AE_TH = (ADDRESS+1)'(ALMOST_EMPTY_TH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [ADDRESS-1:0] r_wr_ptr;
  logic [ADDRESS-1:0] r_rd_ptr;
  logic [ADDRESS:0]   r_count;
  logic [DATA_W-1:0]  r_rdata_p1;
  logic               r_vld_p1;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags decode only the registered count, so they never see input glitches.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  assign w_wr_acc = i_wr_en && !w_full;
  assign w_rd_acc = i_rd_en && !w_empty;

  // Storage is never cleared; a write in the reset cycle is suppressed so the
  // array only ever changes alongside a pointer advance.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc && !i_rst) begin
      r_mem[r_wr_ptr] <= i_wrdata;
    end
  end

  // ---- stage p0 -> p1: pointer/count update and registered read port ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rdata_p1 <= '0;
      r_vld_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rdata_p1 <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Set term is ORed after the clear so a coincident set survives the clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (i_wr_en && w_full)  || (r_overflow  && !i_err_clr);
      r_underflow <= (i_rd_en && w_empty) || (r_underflow && !i_err_clr);
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`endif

  assign o_rdata        = r_rdata_p1;
  assign o_rdata_valid  = r_vld_p1;
  assign o_full         = w_full;
  assign o_empty        = w_empty;
  assign o_almost_full  = (r_count >= C_AF_TH);
  assign o_almost_empty = (r_count <= C_AE_TH);
  assign o_count        = r_count;

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//   Directed self-checking bench for sync_fifo with default parameters
//   (8-bit data, depth 16, almost-full at 12, almost-empty at 2).
//   Inputs change 1 ns after each rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] wrdata;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
  logic       err_clr;
`endif

  int checks;
  int failures;

  sync_fifo dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_wrdata       (wrdata),
    .i_wr_en        (wr_en),
    .i_rd_en        (rd_en),
    .o_rdata        (rdata),
    .o_rdata_valid  (rdata_valid),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (almost_full),
    .o_almost_empty (almost_empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    .o_overflow     (overflow),
    .o_underflow    (underflow),
    .i_err_clr      (err_clr),
`endif
    .o_count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input int exp_count);
    check({tag, ".count"}, 32'(count), 32'(exp_count));
    check({tag, ".empty"}, 32'(empty), 32'(exp_count == 0));
    check({tag, ".full"}, 32'(full), 32'(exp_count == 16));
    check({tag, ".afull"}, 32'(almost_full), 32'(exp_count >= 12));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(exp_count <= 2));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    wrdata   = 8'h00;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    err_clr  = 1'b0;
`endif

    // Reset then idle
    step();
    step();
    rst = 1'b0;
    step();
    check_flags("reset", 0);
    check("reset.rdata", 32'(rdata), 32'h0);
    check("reset.vld", 32'(rdata_valid), 32'h0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("reset.ovf", 32'(overflow), 32'h0);
    check("reset.udf", 32'(underflow), 32'h0);
`endif

    // Fill with 0x00..0x0F
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wrdata = 8'(i);
      step();
      check_flags($sformatf("fill%0d", i), i + 1);
      check("fill.vld", 32'(rdata_valid), 32'h0);
    end

    // 17th write is rejected
    wrdata = 8'hAA;
    step();
    check_flags("ovw", 16);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("ovw.ovf", 32'(overflow), 32'h1);
`endif
    wr_en = 1'b0;

    // Drain 16 back-to-back; 0xAA must never appear
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("drain%0d.rdata", i), 32'(rdata), 32'(i));
      check("drain.vld", 32'(rdata_valid), 32'h1);
      check_flags($sformatf("drain%0d", i), 15 - i);
    end

    // Read on empty is rejected, Rdata holds
    step();
    check("udr.vld", 32'(rdata_valid), 32'h0);
    check("udr.rdata", 32'(rdata), 32'h0F);
    check_flags("udr", 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("udr.udf", 32'(underflow), 32'h1);
    check("udr.ovf", 32'(overflow), 32'h1);
`endif
    rd_en = 1'b0;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // Clear sticky flags; then set-wins-over-clear
    err_clr = 1'b1;
    step();
    check("clr.ovf", 32'(overflow), 32'h0);
    check("clr.udf", 32'(underflow), 32'h0);
    rd_en = 1'b1;
    step();
    check("clrset.udf", 32'(underflow), 32'h1);
    check("clrset.ovf", 32'(overflow), 32'h0);
    rd_en   = 1'b0;
    step();
    check("clr2.udf", 32'(underflow), 32'h0);
    err_clr = 1'b0;
`endif

    // Preload 5 words 0x10..0x14
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wrdata = 8'(8'h10 + i);
      step();
    end
    check_flags("pre5", 5);

    // Streaming: 20 cycles of simultaneous write/read, count stays 5
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wrdata = 8'(8'h15 + i);
      step();
      check_flags($sformatf("strm%0d", i), 5);
      check($sformatf("strm%0d.rdata", i), 32'(rdata), 32'(8'h10 + i));
      check("strm.vld", 32'(rdata_valid), 32'h1);
    end

    // Drain the remaining 5 (0x24..0x28)
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("tail%0d.rdata", i), 32'(rdata), 32'(8'h24 + i));
      check("tail.vld", 32'(rdata_valid), 32'h1);
    end
    check_flags("tail", 0);
    rd_en = 1'b0;
    step();
    check("tail.idle.vld", 32'(rdata_valid), 32'h0);

    // Simultaneous write/read on empty: no bypass
    wr_en  = 1'b1;
    rd_en  = 1'b1;
    wrdata = 8'h5A;
    step();
    check_flags("wrempty", 1);
    check("wrempty.vld", 32'(rdata_valid), 32'h0);
    check("wrempty.rdata", 32'(rdata), 32'h28);
    wr_en = 1'b0;
    step();
    check("wrempty2.rdata", 32'(rdata), 32'h5A);
    check("wrempty2.vld", 32'(rdata_valid), 32'h1);
    check_flags("wrempty2", 0);
    rd_en = 1'b0;

    // Fill to 9 then reset with write and read requested
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wrdata = 8'(8'h60 + i);
      step();
    end
    check_flags("pre9", 9);
    rst    = 1'b1;
    rd_en  = 1'b1;
    wrdata = 8'h77;
    step();
    check_flags("midrst", 0);
    check("midrst.vld", 32'(rdata_valid), 32'h0);
    check("midrst.rdata", 32'(rdata), 32'h0);
    rst    = 1'b0;
    rd_en  = 1'b0;
    wrdata = 8'h33;
    step();
    check_flags("postrst.wr", 1);
    wr_en = 1'b0;
    rd_en = 1'b1;
    step();
    check("postrst.rdata", 32'(rdata), 32'h33);
    check("postrst.vld", 32'(rdata_valid), 32'h1);
    check_flags("postrst.rd", 0);
    rd_en = 1'b0;
    step();
    check("postrst.idle.vld", 32'(rdata_valid), 32'h0);
    check("postrst.hold", 32'(rdata), 32'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
